// File: rtl/numbat_pkg.sv
// Shared definitions for the move_sort sequencer.
//   MAX_POSITIONS          : depth of the sorter RAM
//   MOVE_CAPACITY          : usable entries (one slot is kept free so the
//                            sorter's write address never wraps to 0)
//   DEFAULT_TIMEOUT_CYCLES : default watchdog limit for a sort
//   ctrl_state_t           : sequencer state encoding
package numbat_pkg;

  localparam int MAX_POSITIONS          = 256;
  localparam int MOVE_CAPACITY          = MAX_POSITIONS - 1;
  localparam int DEFAULT_TIMEOUT_CYCLES = 65536;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_LOAD,
    ST_DRAIN,
    ST_LAUNCH,
    ST_WAIT,
    ST_DONE,
    ST_CLEAR,
    ST_HUNG
  } ctrl_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   clear   : synchronous clear to 0 (wins over enable)
//   enable  : increment by one, holding at all-ones
//   count   : current value
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/move_sort_ctrl.sv
// Sequencer owning the move_sort engine for one search node: loads the
// generated move stream into the sorter RAM, launches the sort, watches it
// with a watchdog, reports to the host and clears the sorter on ack.
//   clk, reset_n             : clock, asynchronous active-low reset
//   start, wtm_in, ack       : host request / side to move / acknowledge
//   mv_valid/mv_data/mv_last : move stream in, mv_ready back-pressure out
//   ram_wr_addr_init, ram_wr, ram_wr_data, white_to_move,
//   sort_start, sort_clear   : registered sorter controls
//   sort_complete            : sorter finished
//   busy, done, overflow, timeout, move_count, sort_cycles, irq : host status
//
// state  | meaning
// IDLE   | waiting for host start
// INIT   | reset sorter write address
// LOAD   | writing moves into sorter RAM
// DRAIN  | RAM full, discarding rest of stream
// LAUNCH | last write settling, sort_start issued on exit
// WAIT   | sort running, watchdog counting
// DONE   | result valid, waiting for ack
// CLEAR  | holding sort_clear until sorter drops complete
// HUNG   | watchdog expired, only reset exits
module move_sort_ctrl
  import numbat_pkg::*;
#(
  parameter int RAM_WIDTH          = 0,
  parameter int MAX_POSITIONS_LOG2 = $clog2(MAX_POSITIONS),
  parameter int TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          wtm_in,
  input  logic                          ack,
  input  logic                          mv_valid,
  input  logic [RAM_WIDTH-1:0]          mv_data,
  input  logic                          mv_last,
  output logic                          mv_ready,
  output logic                          ram_wr_addr_init,
  output logic                          ram_wr,
  output logic [RAM_WIDTH-1:0]          ram_wr_data,
  output logic                          white_to_move,
  output logic                          sort_start,
  output logic                          sort_clear,
  input  logic                          sort_complete,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic                          timeout,
  output logic [MAX_POSITIONS_LOG2-1:0] move_count,
  output logic [31:0]                   sort_cycles,
  output logic                          irq
);

  localparam logic [MAX_POSITIONS_LOG2-1:0] CAPACITY  = MAX_POSITIONS_LOG2'(MOVE_CAPACITY);
  localparam logic [31:0]                   WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);

  ctrl_state_t state;
  logic        hs;
  logic        cyc_clear;
  logic        cyc_enable;

  assign hs         = mv_valid && mv_ready;
  assign cyc_clear  = (state == ST_IDLE) && start;
  assign cyc_enable = (state == ST_WAIT);

  sat_counter #(.WIDTH(32)) u_sort_cycles (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cyc_clear),
    .enable  (cyc_enable),
    .count   (sort_cycles)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      mv_ready         <= 1'b0;
      ram_wr_addr_init <= 1'b0;
      ram_wr           <= 1'b0;
      ram_wr_data      <= '0;
      white_to_move    <= 1'b0;
      sort_start       <= 1'b0;
      sort_clear       <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      overflow         <= 1'b0;
      timeout          <= 1'b0;
      move_count       <= '0;
      irq              <= 1'b0;
    end else begin
      ram_wr <= 1'b0;
      irq    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            white_to_move    <= wtm_in;
            move_count       <= '0;
            overflow         <= 1'b0;
            busy             <= 1'b1;
            ram_wr_addr_init <= 1'b1;
            state            <= ST_INIT;
          end
        end
        ST_INIT: begin
          ram_wr_addr_init <= 1'b0;
          mv_ready         <= 1'b1;
          state            <= ST_LOAD;
        end
        ST_LOAD: begin
          if (hs) begin
            if (move_count == CAPACITY) begin
              // RAM full: this beat is dropped even when it is the last one
              overflow <= 1'b1;
              if (mv_last) begin
                mv_ready <= 1'b0;
                state    <= ST_LAUNCH;
              end else begin
                state <= ST_DRAIN;
              end
            end else begin
              ram_wr      <= 1'b1;
              ram_wr_data <= mv_data;
              move_count  <= move_count + MAX_POSITIONS_LOG2'(1);
              if (mv_last) begin
                mv_ready <= 1'b0;
                state    <= ST_LAUNCH;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (hs && mv_last) begin
            mv_ready <= 1'b0;
            state    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          // the final ram_wr is on the bus this cycle; start on the next
          sort_start <= 1'b1;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          sort_start <= 1'b0;
          if (sort_complete) begin
            done  <= 1'b1;
            irq   <= 1'b1;
            state <= ST_DONE;
          end else if (sort_cycles == WDOG_LAST) begin
            timeout <= 1'b1;
            irq     <= 1'b1;
            state   <= ST_HUNG;
          end
        end
        ST_DONE: begin
          if (ack) begin
            done       <= 1'b0;
            sort_clear <= 1'b1;
            state      <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (!sort_complete) begin
            sort_clear <= 1'b0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        ST_HUNG: begin
          state <= ST_HUNG;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_sort_ctrl.sv
module tb_move_sort_ctrl;

  localparam int W    = 16;
  localparam int TO   = 64;
  localparam int CAP  = numbat_pkg::MAX_POSITIONS - 1;
  localparam int MAXP = numbat_pkg::MAX_POSITIONS;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, wtm_in = 1'b0, ack = 1'b0;
  logic        mv_valid = 1'b0, mv_last = 1'b0;
  logic [W-1:0] mv_data = '0;
  logic        mv_ready, ram_wr_addr_init, ram_wr, white_to_move;
  logic [W-1:0] ram_wr_data;
  logic        sort_start, sort_clear, sort_complete;
  logic        busy, done, overflow, timeout, irq;
  logic [7:0]  move_count;
  logic [31:0] sort_cycles;

  move_sort_ctrl #(.RAM_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .wtm_in(wtm_in), .ack(ack),
    .mv_valid(mv_valid), .mv_data(mv_data), .mv_last(mv_last), .mv_ready(mv_ready),
    .ram_wr_addr_init(ram_wr_addr_init), .ram_wr(ram_wr), .ram_wr_data(ram_wr_data),
    .white_to_move(white_to_move), .sort_start(sort_start), .sort_clear(sort_clear),
    .sort_complete(sort_complete), .busy(busy), .done(done), .overflow(overflow),
    .timeout(timeout), .move_count(move_count), .sort_cycles(sort_cycles), .irq(irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int wr_seen = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event occurred that the model did not predict (cycle %0d)", name, cyc);
  endtask

  // Sorter model: complete rises in the lat-th cycle counting the
  // sort_start cycle as 1, stays high until sort_clear is seen.
  int   sorter_lat = 1000000;
  int   sorter_cnt;
  logic sorter_run;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sorter_run <= 1'b0;
      sorter_cnt <= 0;
    end else if (sort_clear) begin
      sorter_run <= 1'b0;
    end else if (sort_start) begin
      sorter_run <= 1'b1;
      sorter_cnt <= 2;
    end else if (sorter_run && sorter_cnt < sorter_lat) begin
      sorter_cnt <= sorter_cnt + 1;
    end
  end
  assign sort_complete = sorter_run && (sorter_cnt >= sorter_lat);

  typedef struct {
    bit is_done;
    int mcount;
    bit ovf;
    int cycles;
    bit wtm;
    int nwr;
    int launch_gap;
  } res_t;

  res_t         res_q[$];
  logic [W-1:0] wr_q[$];
  logic [W-1:0] mv_list[$];

  // Monitor / scoreboard
  initial begin
    res_t r;
    bit   prev_wr = 1'b0;
    bit   prev_irq = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (ram_wr) begin
          check("wr_not_during_init", ram_wr_addr_init, 1'b0);
          if (wr_q.size() == 0) flag("unexpected_ram_wr");
          else check("ram_wr_data", ram_wr_data, wr_q.pop_front());
          wr_seen++;
        end
        if (sort_start) begin
          check("sort_start_not_with_wr", ram_wr, 1'b0);
          check("writes_done_at_launch", wr_q.size(), 0);
          if (res_q.size() > 0) begin
            if (!res_q[0].ovf) check("sort_start_after_last_wr", prev_wr, 1'b1);
            if (res_q[0].launch_gap >= 0)
              check("start_to_sort_start", cyc - start_cyc, res_q[0].launch_gap);
          end
        end
        if (irq) begin
          check("irq_single_pulse", prev_irq, 1'b0);
          if (res_q.size() == 0) flag("unexpected_irq");
          else begin
            r = res_q.pop_front();
            check("done_flag", done, r.is_done);
            check("timeout_flag", timeout, !r.is_done);
            check("move_count", move_count, r.mcount);
            check("overflow", overflow, r.ovf);
            check("sort_cycles", sort_cycles, r.cycles);
            check("white_to_move", white_to_move, r.wtm);
            check("ram_wr_count", wr_seen, r.nwr);
          end
        end
        prev_wr  = ram_wr;
        prev_irq = irq;
      end else begin
        prev_wr  = 1'b0;
        prev_irq = 1'b0;
      end
    end
  end

  function automatic bit any_output_set();
    return |{mv_ready, ram_wr_addr_init, ram_wr, ram_wr_data, white_to_move, sort_start,
             sort_clear, busy, done, overflow, timeout, move_count, sort_cycles, irq};
  endfunction

  // Drive beats 0..k-1 of an n-beat stream with random valid gaps.
  task automatic send_moves(input int n, input int k, input int stall_pct);
    int i = 0;
    int g = 0;
    while (i < k && g < 5000) begin
      @(posedge clk); #1;
      if ($urandom_range(99) < stall_pct) begin
        mv_valid = 1'b0;
        mv_last  = 1'b0;
      end else begin
        mv_valid = 1'b1;
        mv_data  = mv_list[i];
        mv_last  = (i == n - 1);
      end
      @(negedge clk);
      if (mv_valid && mv_ready) i++;
      g++;
    end
    @(posedge clk); #1;
    mv_valid = 1'b0;
    mv_last  = 1'b0;
    check("stream_accepted", i, k);
  endtask

  // Model a request from the rules and push its expectations, then run it.
  task automatic issue(input int n, input int lat, input bit wtm, input int stall_pct,
                       input bit use_list, input int abort_at);
    res_t r;
    int   nw;
    if (!use_list) begin
      mv_list.delete();
      for (int i = 0; i < n; i++) mv_list.push_back(W'($urandom));
    end
    nw = (n > CAP) ? CAP : n;
    if (abort_at > 0) begin
      for (int i = 0; i < abort_at; i++) wr_q.push_back(mv_list[i]);
    end else begin
      for (int i = 0; i < nw; i++) wr_q.push_back(mv_list[i]);
      r.is_done    = (lat <= TO);
      r.cycles     = (lat <= TO) ? lat : TO;
      r.mcount     = nw;
      r.ovf        = (n > CAP);
      r.wtm        = wtm;
      r.nwr        = nw;
      r.launch_gap = (stall_pct == 0) ? n + 3 : -1;
      res_q.push_back(r);
    end
    sorter_lat = lat;
    wr_seen    = 0;
    @(posedge clk); #1;
    start     = 1'b1;
    wtm_in    = wtm;
    start_cyc = cyc;
    @(posedge clk); #1;
    start  = 1'b0;
    wtm_in = ~wtm;
    send_moves(n, (abort_at > 0) ? abort_at : n, stall_pct);
  endtask

  task automatic wait_result();
    int g = 0;
    while (!(done || timeout) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("result_within_budget", done || timeout, 1'b1);
  endtask

  task automatic do_ack(input bit with_start);
    int g = 0;
    int clr = 0;
    @(posedge clk); #1;
    ack = 1'b1;
    if (with_start) begin
      start  = 1'b1;
      wtm_in = 1'b1;
    end
    @(posedge clk); #1;
    ack   = 1'b0;
    start = 1'b0;
    while (busy && g < 100) begin
      @(negedge clk);
      if (sort_clear) clr++;
      g++;
    end
    check("back_to_idle", busy, 1'b0);
    check("sort_clear_cycles", clr, 2);
    check("complete_low_at_idle", sort_complete, 1'b0);
    check("done_low_after_ack", done, 1'b0);
    if (with_start) begin
      repeat (4) @(negedge clk);
      check("collision_start_dropped_busy", busy, 1'b0);
      check("collision_start_dropped_init", ram_wr_addr_init, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "tb_move_sort_ctrl global timeout");
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("reset_outputs_zero", any_output_set(), 1'b0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outputs_zero", any_output_set(), 1'b0);

    // basic sort: evals {3,-7,12,0,12}, sorter takes 40 cycles
    mv_list = '{16'd3, 16'hFFF9, 16'd12, 16'd0, 16'd12};
    issue(5, 40, 1'b1, 0, 1'b1, 0);
    wait_result();
    do_ack(1'b0);

    // stalled handshake, 100 moves
    issue(100, $urandom_range(2, TO - 1), 1'b0, 30, 1'b0, 0);
    wait_result();
    do_ack(1'b0);

    // boundaries: single move, exact capacity, watchdog-edge completion
    issue(1, 2, 1'b1, 0, 1'b0, 0);
    wait_result();
    do_ack(1'b0);
    issue(CAP, TO, 1'b0, 0, 1'b0, 0);
    wait_result();
    do_ack(1'b0);

    // random requests
    for (int t = 0; t < 6; t++) begin
      issue($urandom_range(1, 40), $urandom_range(2, TO - 1), 1'($urandom),
            ($urandom_range(1) == 0) ? 0 : 40, 1'b0, 0);
      wait_result();
      do_ack(1'b0);
    end

    // overflow: MAX_POSITIONS+3 moves
    issue(MAXP + 3, 20, 1'b1, 10, 1'b0, 0);
    wait_result();
    do_ack(1'b0);

    // ack and start collide in DONE
    issue(7, 10, 1'b0, 0, 1'b0, 0);
    wait_result();
    do_ack(1'b1);

    // watchdog: sorter never completes
    issue(4, 1000000, 1'b1, 0, 1'b0, 0);
    wait_result();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ack   = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    repeat (3) @(negedge clk);
    check("hung_busy", busy, 1'b1);
    check("hung_timeout", timeout, 1'b1);
    check("hung_no_init", ram_wr_addr_init, 1'b0);
    check("hung_no_clear", sort_clear, 1'b0);
    check("hung_cycles_frozen", sort_cycles, TO);
    #2;
    reset_n = 1'b0;
    #1;
    check("hung_reset_outputs_zero", any_output_set(), 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // reset in the middle of LOAD
    issue(10, 30, 1'b1, 0, 1'b0, 3);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midload_reset_outputs_zero", any_output_set(), 1'b0);
    check("midload_writes_seen", wr_q.size(), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mv_list = '{16'd3, 16'hFFF9, 16'd12, 16'd0, 16'd12};
    issue(5, 40, 1'b1, 0, 1'b1, 0);
    wait_result();
    do_ack(1'b0);

    repeat (3) @(negedge clk);
    check("write_queue_empty", wr_q.size(), 0);
    check("result_queue_empty", res_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
